// File: rtl/spi_master_gen_pkg.sv
// Shared types for the SPI master: FSM states, latched mode and edge-counter width.
package spi_pkg;

  localparam int DATA_W_DEF    = 8;
  localparam int MAX_BYTES_DEF = 4;
  localparam int BIT_CNT_W     = $clog2(MAX_BYTES_DEF*DATA_W_DEF*2+1);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

endpackage

// File: rtl/spi_master_gen_tick_gen.sv
// SCLK half-period divider: counts 0..CLK_DIV-1 while enabled, ticks on the last count.
module spi_tick_gen #(
  parameter int CLK_DIV = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == CNT_W'(CLK_DIV-1));

  // Every state change happens on a tick or while disabled, so wrapping here
  // also clears the count at each state change.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || tick) cnt_d = '0;
    else             cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/spi_master_gen.sv
// Parametrised SPI master (all CPOL/CPHA modes, 1..MAX_BYTES bytes, NUM_CS selects).
// Build option: SPI_LOOPBACK_EN samples mosi internally instead of the miso pin.
module spi_master_gen
  import spi_pkg::*;
#(
  parameter int CLK_DIV   = 10,
  parameter int DATA_W    = 8,
  parameter int MAX_BYTES = 4,
  parameter int NUM_CS    = 2,
  localparam int CS_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1,
  localparam int NB_W     = $clog2(MAX_BYTES+1),
  localparam int TOT_W    = MAX_BYTES*DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cpol,
  input  logic              cpha,
  input  logic [CS_W-1:0]   cs_sel,
  input  logic [NB_W-1:0]   num_bytes,
  input  logic [TOT_W-1:0]  tx_data,
  output logic [TOT_W-1:0]  rx_data,
  output logic              busy,
  output logic              done,
  output logic              sclk,
  output logic              mosi,
  input  logic              miso,
  output logic [NUM_CS-1:0] cs_n,
  output state_t            dbg_state
);

  localparam int EDGE_W = $clog2(TOT_W*2+1);

  state_t             state_q, state_d;
  spi_mode_t          mode_q, mode_d;
  logic [CS_W-1:0]    cs_q, cs_d;
  logic [NB_W-1:0]    nb_q, nb_d;
  logic [TOT_W-1:0]   tx_sh_q, tx_sh_d;
  logic [TOT_W-1:0]   rx_sh_q, rx_sh_d;
  logic [TOT_W-1:0]   rx_data_q, rx_data_d;
  logic [EDGE_W-1:0]  edge_q, edge_d;
  logic               sclk_q, sclk_d;
  logic               mosi_q, mosi_d;
  logic               done_q, done_d;

  logic               tick;
  logic               sample_in;
  logic [TOT_W-1:0]   ser;
  logic [TOT_W-1:0]   rx_pack;
  logic [EDGE_W-1:0]  last_edge;
  logic               odd_edge, final_edge, sample_now, shift_now, accept;

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (state_q != IDLE),
    .tick (tick)
  );

`ifdef SPI_LOOPBACK_EN
  logic unused_miso;
  assign unused_miso = miso;
  assign sample_in   = mosi_q;
`else
  assign sample_in   = miso;
`endif

  // Reorder so the serial stream always leaves from the MSB: byte 0 first, MSB first.
  always_comb begin
    ser = '0;
    for (int b = 0; b < MAX_BYTES; b++)
      ser[(MAX_BYTES-1-b)*DATA_W +: DATA_W] = tx_data[b*DATA_W +: DATA_W];
  end

  // Received bits enter at the LSB, so the last byte of an n-byte frame ends up lowest.
  always_comb begin
    rx_pack = '0;
    for (int n = 1; n <= MAX_BYTES; n++)
      if (nb_q == NB_W'(n))
        for (int b = 0; b < n; b++)
          rx_pack[b*DATA_W +: DATA_W] = rx_sh_q[(n-1-b)*DATA_W +: DATA_W];
  end

  assign last_edge  = EDGE_W'(32'(nb_q) * 32'(2*DATA_W));
  assign odd_edge   = ~edge_q[0];
  assign final_edge = (edge_q + EDGE_W'(1)) == last_edge;
  assign sample_now = mode_q.cpha ? !odd_edge : odd_edge;
  assign shift_now  = mode_q.cpha ? odd_edge : (!odd_edge && !final_edge);

  // start is a level request honoured only in IDLE with a legal byte count;
  // there is no ready output, busy high means any start is dropped.
  assign accept = start && (num_bytes != NB_W'(0)) && (num_bytes <= NB_W'(MAX_BYTES));

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    cs_d      = cs_q;
    nb_d      = nb_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    edge_d    = edge_q;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        sclk_d = cpol;
        if (accept) begin
          mode_d    = '{cpol: cpol, cpha: cpha};
          cs_d      = cs_sel;
          nb_d      = num_bytes;
          tx_sh_d   = cpha ? ser : {ser[TOT_W-2:0], 1'b0};
          mosi_d    = cpha ? 1'b0 : ser[TOT_W-1];
          rx_sh_d   = '0;
          rx_data_d = '0;
          edge_d    = '0;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        sclk_d = mode_q.cpol;
        if (tick) state_d = SHIFT;
      end
      SHIFT: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          edge_d = edge_q + EDGE_W'(1);
          if (sample_now) rx_sh_d = {rx_sh_q[TOT_W-2:0], sample_in};
          if (shift_now) begin
            mosi_d  = tx_sh_q[TOT_W-1];
            tx_sh_d = {tx_sh_q[TOT_W-2:0], 1'b0};
          end
          if (final_edge) state_d = HOLD;
        end
      end
      HOLD: begin
        sclk_d = mode_q.cpol;
        if (tick) begin
          done_d    = 1'b1;
          rx_data_d = rx_pack;
          state_d   = GAP;
        end
      end
      GAP: begin
        if (tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      mode_q    <= '0;
      cs_q      <= '0;
      nb_q      <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      edge_q    <= '0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      cs_q      <= cs_d;
      nb_q      <= nb_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      edge_q    <= edge_d;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      done_q    <= done_d;
    end
  end

  // An out-of-range cs_sel matches no index, so every select stays high.
  always_comb begin
    cs_n = '1;
    if (state_q == SETUP || state_q == SHIFT || state_q == HOLD)
      for (int i = 0; i < NUM_CS; i++)
        if (cs_q == CS_W'(i)) cs_n[i] = 1'b0;
  end

  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign sclk      = sclk_q;
  assign mosi      = mosi_q;
  assign rx_data   = rx_data_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_master_gen.sv
// Self-checking bench for spi_master_gen: SPI slave model, byte scoreboard, randomized transfers.
module tb_spi_master_gen;
  import spi_pkg::*;

  localparam int CLK_DIV = 2;
  localparam int DW      = 8;
  localparam int MB      = 4;
  localparam int NCS     = 2;
  localparam int TOT     = MB*DW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             cpol = 1'b0;
  logic             cpha = 1'b0;
  logic [0:0]       cs_sel = '0;
  logic [2:0]       num_bytes = '0;
  logic [TOT-1:0]   tx_data = '0;
  logic [TOT-1:0]   rx_data;
  logic             busy, done, sclk, mosi;
  logic             miso = 1'b0;
  logic [NCS-1:0]   cs_n;
  state_t           dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  spi_master_gen #(.CLK_DIV(CLK_DIV), .DATA_W(DW), .MAX_BYTES(MB), .NUM_CS(NCS)) dut (
    .clk(clk), .rst(rst), .start(start), .cpol(cpol), .cpha(cpha), .cs_sel(cs_sel),
    .num_bytes(num_bytes), .tx_data(tx_data), .rx_data(rx_data), .busy(busy), .done(done),
    .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [TOT-1:0] keep_bytes(input logic [TOT-1:0] v, input int nb);
    logic [TOT-1:0] r;
    r = '0;
    for (int b = 0; b < MB; b++)
      if (b < nb) r[b*DW +: DW] = v[b*DW +: DW];
    return r;
  endfunction

  // One transfer, observed at negedges. The slave presents bits on its shift edge
  // and the bench reads mosi on its sample edge.
  task automatic run_txn(input logic cpol_i, input logic cpha_i, input logic cs_i, input int nb,
                         input logic [TOT-1:0] tx, input logic [TOT-1:0] sl, input int poke_at);
    logic [DW-1:0] exp_q[$];
    logic          sl_bits[$];
    logic [DW-1:0] got_byte;
    logic [NCS-1:0] exp_cs;
    logic [TOT-1:0] exp_rx;
    int  sl_idx, got_bits, samples, edges, dones, done_cyc, fall_cyc, last_edge_cyc;
    int  lat, budget;
    bit  cs_prev, cs_act, cs_bad, period_bad, finished, leading;
    logic prev_sclk;

    exp_q.delete();
    sl_bits.delete();
    for (int b = 0; b < nb; b++) begin
      exp_q.push_back(tx[b*DW +: DW]);
      for (int i = DW-1; i >= 0; i--) sl_bits.push_back(sl[b*DW + i]);
    end
`ifdef SPI_LOOPBACK_EN
    exp_rx = keep_bytes(tx, nb);
`else
    exp_rx = keep_bytes(sl, nb);
`endif
    exp_cs = ~(NCS'(1) << cs_i);
    lat    = CLK_DIV*(2 + 2*nb*DW);
    budget = lat + CLK_DIV + 20;
    sl_idx = 0; got_bits = 0; got_byte = '0; samples = 0; edges = 0; dones = 0;
    done_cyc = -1; fall_cyc = -1; last_edge_cyc = 0;
    cs_prev = 0; cs_bad = 0; period_bad = 0; finished = 0;

    @(negedge clk);
    cpol = cpol_i; cpha = cpha_i; cs_sel = cs_i; num_bytes = 3'(nb); tx_data = tx;
`ifdef SPI_LOOPBACK_EN
    miso = 1'bx;
`endif
    repeat (3) @(negedge clk);
    check("idle_sclk", sclk, cpol_i);
    check("idle_cs_n", cs_n, {NCS{1'b1}});
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_accept", busy, 1'b1);
    prev_sclk = sclk;

    for (int cyc = 1; cyc <= budget && !finished; cyc++) begin
      start = (cyc == poke_at);
      if (cyc == poke_at) begin
        tx_data = ~tx;
        num_bytes = 3'd1;
      end
      @(negedge clk);
      cs_act = (cs_n != {NCS{1'b1}});
      if (cs_act && cs_n != exp_cs) cs_bad = 1;
      if (cs_act && !cs_prev && !cpha_i) begin
`ifndef SPI_LOOPBACK_EN
        if (sl_idx < sl_bits.size()) begin miso = sl_bits[sl_idx]; sl_idx++; end
`endif
      end
      if (sclk !== prev_sclk) begin
        edges++;
        if (!cs_act) cs_bad = 1;
        if (edges > 1 && (cyc - last_edge_cyc) != CLK_DIV) period_bad = 1;
        last_edge_cyc = cyc;
        leading = (sclk != cpol_i);
        if (leading ^ cpha_i) begin
          samples++;
          got_byte = {got_byte[DW-2:0], mosi};
          got_bits++;
          if (got_bits == DW) begin
            got_bits = 0;
            if (exp_q.size() > 0) check("mosi_byte", got_byte, exp_q.pop_front());
            else check("mosi_extra_byte", got_byte, 'x);
          end
        end else begin
`ifndef SPI_LOOPBACK_EN
          if (sl_idx < sl_bits.size()) begin miso = sl_bits[sl_idx]; sl_idx++; end
`endif
        end
      end
      if (done) begin
        dones++;
        if (dones == 1) begin
          done_cyc = cyc;
          check("latency", cyc, lat);
          check("rx_data", rx_data, exp_rx);
          check("sclk_end", sclk, cpol_i);
          check("cs_n_at_done", cs_n, {NCS{1'b1}});
        end
      end
      if (!busy) begin
        fall_cyc = cyc;
        finished = 1;
      end
      prev_sclk = sclk;
      cs_prev = cs_act;
    end
    start = 1'b0;

    check("finished_in_budget", finished, 1'b1);
    check("done_count", dones, 1);
    check("sample_edges", samples, nb*DW);
    check("sclk_edges", edges, 2*nb*DW);
    check("cs_n_pattern", cs_bad, 1'b0);
    check("sclk_period", period_bad, 1'b0);
    check("gap_cycles", fall_cyc - done_cyc, CLK_DIV);
    repeat (3) @(negedge clk);
    check("rx_hold", rx_data, exp_rx);
    check("idle_sclk_after", sclk, cpol_i);
  endtask

  task automatic bad_start(input int nb);
    bit busy_seen;
    busy_seen = 0;
    @(negedge clk);
    num_bytes = 3'(nb);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2*CLK_DIV + 4; i++) begin
      if (busy || cs_n != {NCS{1'b1}}) busy_seen = 1;
      @(negedge clk);
    end
    check("ignored_start", busy_seen, 1'b0);
  endtask

  task automatic reset_mid();
    int dones;
    dones = 0;
    @(negedge clk);
    cpol = 1'b0; cpha = 1'b0; cs_sel = 1'b0; num_bytes = 3'd3; tx_data = $urandom;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (CLK_DIV*(1 + 2*DW + 6)) @(negedge clk);
    check("mid_state_shift", dbg_state, SHIFT);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_cs_n", cs_n, {NCS{1'b1}});
    check("rst_sclk", sclk, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_data", rx_data, '0);
    for (int i = 0; i < 150; i++) begin
      if (done) dones++;
      @(negedge clk);
    end
    check("rst_no_done", dones, 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_sclk", sclk, 1'b0);
    check("reset_mosi", mosi, 1'b0);
    check("reset_cs_n", cs_n, {NCS{1'b1}});
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_rx_data", rx_data, '0);
    check("reset_state", dbg_state, IDLE);
    rst = 1'b0;

    run_txn(1'b0, 1'b0, 1'b0, 1, 32'h0000_00A5, 32'h0000_003C, -1);
    run_txn(1'b1, 1'b1, 1'b1, 3, 32'h0002_2D0A, $urandom, -1);
    run_txn(1'b0, 1'b1, 1'b0, 1, $urandom, 32'h0000_0081, -1);
    run_txn(1'b1, 1'b0, 1'b0, 1, $urandom, 32'h0000_0081, -1);
    run_txn(1'b0, 1'b0, 1'b1, 2, $urandom, $urandom, 20);
    bad_start(0);
    bad_start(5);
    reset_mid();
    run_txn(1'b0, 1'b0, 1'b0, 2, $urandom, $urandom, -1);
    run_txn(1'b0, 1'b0, 1'b0, 4, 32'hDEAD_BEEF, $urandom, -1);
    for (int t = 0; t < 8; t++)
      run_txn(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              $urandom_range(1, MB), $urandom, $urandom, $urandom_range(0, 1) ? 30 : -1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
